axi_lite_mem_responder: RTL and testbench

AXI4-Lite slave responder that serves the cache FSM's line fills and write-backs.
- Accepts read-start (AR/R) and write-back (AW/W/B) transactions.
- Backed by a word-addressed, byte-strobed memory array.
- Read latency is programmable, so cache stall paths can be exercised with realistic delays.
- Sits at the memory end of the cache subsystem's AXI4-Lite link, opposite the cache-side master.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/mem_array_be.sv | 34 +++
 rtl/axi_lite_mem_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_lite_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite memory responder
// and the cache-side master that talks to it.
package axi_lite_pkg;

    // Only OKAY and SLVERR are ever produced by the responder.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } t_resp;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } t_rd_state;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } t_wr_state;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_array_be.sv
// Word-addressed memory with per-byte write enables and an asynchronous
// read port. Each byte lane is its own array so a lane write never has to
// read-modify-write its neighbours. The read is registered by the user.
module mem_array_be #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [$clog2(MEM_DEPTH)-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic [DATA_WIDTH/8-1:0]       i_wstrb,
    input  logic [$clog2(MEM_DEPTH)-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0]         o_rdata
);

    localparam int STRB = DATA_WIDTH / 8;

    generate
        for (genvar gi = 0; gi < STRB; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];

            // Byte lane write, gated by its strobe; contents are never reset.
            always_ff @(posedge i_clk) begin
                if (i_we && i_wstrb[gi]) begin
                    lane_mem[i_waddr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = lane_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave serving cache line fills and write-backs from a
// byte-strobed memory, with a programmable read latency.
// Optional build macro AXI_MEM_OOR_ERR_EN: when defined, byte addresses at
// or above MEM_DEPTH*STRB get SLVERR (reads return zero, writes are dropped);
// when undefined the word index simply wraps and every response is OKAY.
module axi_lite_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    import axi_lite_pkg::*;

    localparam int STRB    = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int ADDR_HI = IDX_LSB + IDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    // Range decode on the incoming addresses, captured with the address.
    logic ar_oor;
    logic aw_oor;
`ifdef AXI_MEM_OOR_ERR_EN
    assign ar_oor = |(i_araddr >> ADDR_HI);
    assign aw_oor = |(i_awaddr >> ADDR_HI);
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, the upper bits) are
    // intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_araddr, i_awaddr};

    // ---------------- read channel ----------------
    t_rd_state             rd_state_reg, rd_state_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    t_resp                 rresp_reg, rresp_next;
    logic [3:0]            rd_cnt_reg, rd_cnt_next;
    logic [IDX_W-1:0]      rd_idx_reg, rd_idx_next;
    logic                  rd_oor_reg, rd_oor_next;

    // ---------------- write channel ----------------
    t_wr_state             wr_state_reg, wr_state_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    t_resp                 bresp_reg, bresp_next;
    logic                  aw_got_reg, aw_got_next;
    logic                  w_got_reg, w_got_next;
    logic [IDX_W-1:0]      wr_idx_reg, wr_idx_next;
    logic                  wr_oor_reg, wr_oor_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB-1:0]       wstrb_reg, wstrb_next;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    mem_array_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_idx_reg),
        .i_wdata (wdata_reg),
        .i_wstrb (wstrb_reg),
        .i_raddr (rd_idx_reg),
        .o_rdata (mem_rdata)
    );

    // Read FSM next state: count down the latency, then present the word.
    always_comb begin
        rd_state_next = rd_state_reg;
        arready_next  = arready_reg;
        rvalid_next   = rvalid_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_idx_next   = rd_idx_reg;
        rd_oor_next   = rd_oor_reg;
        case (rd_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (i_arvalid && arready_reg) begin
                    arready_next  = 1'b0;
                    rd_idx_next   = i_araddr[IDX_LSB +: IDX_W];
                    rd_oor_next   = ar_oor;
                    rd_cnt_next   = CNT_LOAD;
                    rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_reg == 4'd0) begin
                    // Sampling here sees pre-write data if a write commits
                    // on this same edge.
                    rvalid_next   = 1'b1;
                    rdata_next    = rd_oor_reg ? '0 : mem_rdata;
                    rresp_next    = rd_oor_reg ? SLVERR : OKAY;
                    rd_state_next = R_RESP;
                end else begin
                    rd_cnt_next = rd_cnt_reg - 4'd1;
                end
            end
            R_RESP: begin
                if (i_rready) begin
                    // arready rises with the handshake so the next AR can be
                    // taken one cycle later.
                    rvalid_next   = 1'b0;
                    arready_next  = 1'b1;
                    rd_state_next = R_IDLE;
                end
            end
            default: begin
                rd_state_next = R_IDLE;
                arready_next  = 1'b0;
                rvalid_next   = 1'b0;
            end
        endcase
    end

    // Write FSM next state: collect AW and W in any order, then commit.
    always_comb begin
        wr_state_next = wr_state_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        aw_got_next   = aw_got_reg;
        w_got_next    = w_got_reg;
        wr_idx_next   = wr_idx_reg;
        wr_oor_next   = wr_oor_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        mem_we        = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (aw_got_reg && w_got_reg) begin
                    mem_we        = !wr_oor_reg;
                    bvalid_next   = 1'b1;
                    bresp_next    = wr_oor_reg ? SLVERR : OKAY;
                    aw_got_next   = 1'b0;
                    w_got_next    = 1'b0;
                    wr_state_next = W_RESP;
                end else begin
                    awready_next = !aw_got_reg;
                    wready_next  = !w_got_reg;
                    if (i_awvalid && awready_reg) begin
                        aw_got_next  = 1'b1;
                        awready_next = 1'b0;
                        wr_idx_next  = i_awaddr[IDX_LSB +: IDX_W];
                        wr_oor_next  = aw_oor;
                    end
                    if (i_wvalid && wready_reg) begin
                        w_got_next  = 1'b1;
                        wready_next = 1'b0;
                        wdata_next  = i_wdata;
                        wstrb_next  = i_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    bvalid_next   = 1'b0;
                    awready_next  = 1'b1;
                    wready_next   = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rd_state_reg <= R_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= OKAY;
            rd_cnt_reg   <= '0;
            rd_idx_reg   <= '0;
            rd_oor_reg   <= 1'b0;
            wr_state_reg <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= OKAY;
            aw_got_reg   <= 1'b0;
            w_got_reg    <= 1'b0;
            wr_idx_reg   <= '0;
            wr_oor_reg   <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            arready_reg  <= arready_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_idx_reg   <= rd_idx_next;
            rd_oor_reg   <= rd_oor_next;
            wr_state_reg <= wr_state_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
            aw_got_reg   <= aw_got_next;
            w_got_reg    <= w_got_next;
            wr_idx_reg   <= wr_idx_next;
            wr_oor_reg   <= wr_oor_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
        end
    end

    assign o_arready = arready_reg;
    assign o_rvalid  = rvalid_reg;
    assign o_rdata   = rdata_reg;
    assign o_rresp   = rresp_reg;
    assign o_awready = awready_reg;
    assign o_wready  = wready_reg;
    assign o_bvalid  = bvalid_reg;
    assign o_bresp   = bresp_reg;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder with hand-computed expectations.
// Build with +define+AXI_MEM_OOR_ERR_EN to exercise the range-error variant.
module tb_axi_lite_mem_responder;

    import axi_lite_pkg::*;

    localparam int READ_LATENCY = 2;

    logic        clk;
    logic        arst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vec_cnt = 0;
    int err_cnt = 0;

    axi_lite_mem_responder #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (1024),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .i_clk     (clk),
        .i_arst    (arst),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_araddr  (araddr),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rvalid  (rvalid),
        .i_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        check("wr_ready_wait", 64'(n < 20), 64'd1);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid_early", 64'(bvalid), 64'd0);
        tick();
        check("wr_bvalid", 64'(bvalid), 64'd1);
        check("wr_bresp", 64'(bresp), 64'(exp_resp));
        $display("wr addr=%h data=%h strb=%h bresp=%b", addr, data, strb, bresp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_bvalid_drop", 64'(bvalid), 64'd0);
        check("wr_awready_back", 64'(awready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        int n;
        int lat;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check("rd_ready_wait", 64'(n < 20), 64'd1);
        araddr = addr; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(READ_LATENCY));
        check("rd_data", 64'(rdata), 64'(exp_data));
        check("rd_resp", 64'(rresp), 64'(exp_resp));
        $display("rd addr=%h data=%h rresp=%b latency=%0d", addr, rdata, rresp, lat);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_rvalid_drop", 64'(rvalid), 64'd0);
        check("rd_arready_back", 64'(arready), 64'd1);
    endtask

    initial begin
        logic [31:0] exp_w0;
        logic [31:0] exp_oor_data;
        logic [1:0]  exp_oor_resp;

        arst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rresp", 64'(rresp), 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        arst = 1'b0;
        check("rel_arready_pre", 64'(arready), 64'd0);
        tick();
        check("rel_arready", 64'(arready), 64'd1);
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_wready", 64'(wready), 64'd1);

        // 1: full write then read
        do_write(32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
        do_read(32'h10, 32'hDEADBEEF, RESP_OKAY);

        // 2: W three cycles ahead of AW, partial strobe
        wdata = 32'h0000AAAA; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_wready_low", 64'(wready), 64'd0);
            check("t2_awready_high", 64'(awready), 64'd1);
            if (i < 2) tick();
        end
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t2_bvalid_early", 64'(bvalid), 64'd0);
        tick();
        check("t2_bvalid", 64'(bvalid), 64'd1);
        check("t2_bresp", 64'(bresp), 64'(RESP_OKAY));
        $display("wr addr=00000010 data=0000aaaa strb=3 bresp=%b (W before AW)", bresp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h10, 32'hDEADAAAA, RESP_OKAY);

        // 3: both responses stalled for 5 cycles
        awaddr = 32'h30; awvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h10; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_rvalid", 64'(rvalid), 64'd1);
            check("t3_rdata", 64'(rdata), 64'hDEADAAAA);
            check("t3_bvalid", 64'(bvalid), 64'd1);
            check("t3_bresp", 64'(bresp), 64'(RESP_OKAY));
            check("t3_arready", 64'(arready), 64'd0);
            check("t3_awready", 64'(awready), 64'd0);
            check("t3_wready", 64'(wready), 64'd0);
            tick();
        end
        $display("stall rd data=%h wr bresp=%b", rdata, bresp);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        check("t3_rvalid_drop", 64'(rvalid), 64'd0);
        check("t3_bvalid_drop", 64'(bvalid), 64'd0);
        do_read(32'h30, 32'h11223344, RESP_OKAY);

        // 4: read sample and write commit on the same edge
        do_write(32'h20, 32'h1, 4'hF, RESP_OKAY);
        araddr = 32'h20; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        awaddr = 32'h20; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t4_rvalid_early", 64'(rvalid), 64'd0);
        check("t4_bvalid_early", 64'(bvalid), 64'd0);
        tick();
        check("t4_rvalid", 64'(rvalid), 64'd1);
        check("t4_bvalid", 64'(bvalid), 64'd1);
        check("t4_old_data", 64'(rdata), 64'h1);
        $display("collide rd data=%h wr bresp=%b", rdata, bresp);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(32'h20, 32'h2, RESP_OKAY);

        // 5: address beyond the array
`ifdef AXI_MEM_OOR_ERR_EN
        exp_w0       = 32'hCAFEF00D;
        exp_oor_data = 32'h0;
        exp_oor_resp = RESP_SLVERR;
`else
        exp_w0       = 32'h12345678;
        exp_oor_data = 32'h12345678;
        exp_oor_resp = RESP_OKAY;
`endif
        do_write(32'h0, 32'hCAFEF00D, 4'hF, RESP_OKAY);
        do_write(32'h1000, 32'h12345678, 4'hF, exp_oor_resp);
        do_read(32'h0, exp_w0, RESP_OKAY);
        do_read(32'h1000, exp_oor_data, exp_oor_resp);

        // Zero strobe commits nothing but still answers OKAY
        do_write(32'h10, 32'hFFFFFFFF, 4'h0, RESP_OKAY);
        do_read(32'h10, 32'hDEADAAAA, RESP_OKAY);

        // 6: reset while read in R_WAIT and write in W_RESP
        araddr = 32'h10; arvalid = 1'b1;
        awaddr = 32'h40; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t6_bvalid_pre", 64'(bvalid), 64'd1);
        check("t6_rvalid_pre", 64'(rvalid), 64'd0);
        arst = 1'b1;
        #1;
        check("t6_rst_bvalid", 64'(bvalid), 64'd0);
        check("t6_rst_rvalid", 64'(rvalid), 64'd0);
        check("t6_rst_arready", 64'(arready), 64'd0);
        check("t6_rst_awready", 64'(awready), 64'd0);
        check("t6_rst_wready", 64'(wready), 64'd0);
        check("t6_rst_rdata", 64'(rdata), 64'd0);
        check("t6_rst_bresp", 64'(bresp), 64'd0);
        tick();
        tick();
        arst = 1'b0;
        tick();
        check("t6_rel_arready", 64'(arready), 64'd1);
        check("t6_rel_awready", 64'(awready), 64'd1);
        check("t6_rel_wready", 64'(wready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_rvalid", 64'(rvalid), 64'd0);
            check("t6_no_bvalid", 64'(bvalid), 64'd0);
            tick();
        end
        $display("reset abort done rvalid=%b bvalid=%b", rvalid, bvalid);
        do_read(32'h40, 32'h55, RESP_OKAY);
        do_read(32'h10, 32'hDEADAAAA, RESP_OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
